// File: rtl/mem_copy_initiator_if.sv
// mem_copy_initiator_if: picorv32-style native memory bus between an initiator and a responder
interface mem_copy_initiator_if;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );
  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_copy_initiator.sv
// mem_copy_initiator: copies a block of words with one read then one write per word, with per-transaction timeout
module mem_copy_initiator #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             err,
  mem_copy_initiator_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD, RD_GAP, WR, WR_GAP, DONE} state_t;
  state_t           state;
  logic [31:0]      src;
  logic [31:0]      dst;
  logic [CNT_W-1:0] remaining;
  logic [31:0]      wait_cnt;
  logic             fire;
  logic             timeout_hit;
  assign bus.mem_instr = 1'b0;
  assign fire          = bus.mem_valid && bus.mem_ready;
  assign timeout_hit   = (TIMEOUT != 0) && (wait_cnt == TIMEOUT - 1);
  // mem_wdata doubles as the captured read word between the read and the write
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      src           <= '0;
      dst           <= '0;
      remaining     <= '0;
      wait_cnt      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      bus.mem_valid <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wstrb <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          err  <= 1'b0;
          if (word_count != '0) begin
            src           <= {src_addr[31:2], 2'b00};
            dst           <= {dst_addr[31:2], 2'b00};
            remaining     <= word_count;
            wait_cnt      <= '0;
            bus.mem_valid <= 1'b1;
            bus.mem_addr  <= {src_addr[31:2], 2'b00};
            bus.mem_wstrb <= 4'h0;
            state         <= RD;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        RD: if (fire) begin
          bus.mem_valid <= 1'b0;
          bus.mem_wdata <= bus.mem_rdata;
          state         <= RD_GAP;
        end else if (timeout_hit) begin
          bus.mem_valid <= 1'b0;
          err           <= 1'b1;
          done          <= 1'b1;
          state         <= DONE;
        end else begin
          wait_cnt <= wait_cnt + 32'd1;
        end
        RD_GAP: begin
          bus.mem_valid <= 1'b1;
          bus.mem_addr  <= dst;
          bus.mem_wstrb <= 4'hF;
          wait_cnt      <= '0;
          state         <= WR;
        end
        WR: if (fire) begin
          bus.mem_valid <= 1'b0;
          bus.mem_wstrb <= 4'h0;
          src           <= src + 32'd4;
          dst           <= dst + 32'd4;
          remaining     <= remaining - 1'b1;
          state         <= WR_GAP;
        end else if (timeout_hit) begin
          bus.mem_valid <= 1'b0;
          err           <= 1'b1;
          done          <= 1'b1;
          state         <= DONE;
        end else begin
          wait_cnt <= wait_cnt + 32'd1;
        end
        WR_GAP: if (remaining != '0) begin
          bus.mem_valid <= 1'b1;
          bus.mem_addr  <= src;
          wait_cnt      <= '0;
          state         <= RD;
        end else begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
